// File: rtl/gf2m_digit_serial_mult.sv
// gf2m_digit_serial_mult: digit-serial GF(2^M) multiplier, D bits of b per cycle, valid/ready handshakes.
// Defining GF_MULT_ACC_EN adds in_acc: the result is then optionally XOR-accumulated into out_y.
module gf2m_digit_serial_mult #(
    parameter int M = 8,
    parameter int D = 2,
    parameter logic [M-1:0] POLY = 8'h1B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_a,
    input  logic [M-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_y
`ifdef GF_MULT_ACC_EN
    ,
    input  logic         in_acc
`endif
);
    localparam int N = (M + D - 1) / D;
    localparam int NB = N * D;
    localparam int W = M + D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] PM = W'({1'b1, POLY});

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_q, state_d;
    logic [M-1:0] a_q, a_d, acc_q, acc_d, y_q, y_d, acc_next;
    logic [NB-1:0] b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [D-1:0] dig;
    logic [W-1:0] t;
`ifdef GF_MULT_ACC_EN
    logic accm_q, accm_d;
`endif

    assign dig = b_q[NB-1 -: D];
    assign in_ready = (state_q == IDLE) && !rst;
    assign out_valid = state_q == DONE;
    assign out_y = y_q;

    // One digit step: shift acc by x^D, add a*digit, then fold bits M+D-1..M back via P(x).
    always_comb begin
        t = {acc_q, {D{1'b0}}};
        for (int j = 0; j < D; j++) t = t ^ (dig[j] ? W'(a_q) << j : '0);
        for (int i = W - 1; i >= M; i--) t = t ^ (t[i] ? PM << (i - M) : '0);
        acc_next = t[M-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        y_d = y_q;
`ifdef GF_MULT_ACC_EN
        accm_d = accm_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                a_d = in_a;
                b_d = NB'(in_b);
                acc_d = '0;
                cnt_d = '0;
                state_d = BUSY;
`ifdef GF_MULT_ACC_EN
                accm_d = in_acc;
`endif
            end
            BUSY: begin
                acc_d = acc_next;
                b_d = b_q << D;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
`ifdef GF_MULT_ACC_EN
                    y_d = acc_next ^ (accm_q ? y_q : '0);
`else
                    y_d = acc_next;
`endif
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            y_q <= '0;
`ifdef GF_MULT_ACC_EN
            accm_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            y_q <= y_d;
`ifdef GF_MULT_ACC_EN
            accm_q <= accm_d;
`endif
        end
    end
endmodule
